// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one Hack ALU between two requesters
module hack_alu #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [5:0]   ctrl_i,
  output logic [W-1:0] out_o
);
  logic [W-1:0] xa, xb, ya, yb, f;
  // ctrl_i = {zx, nx, zy, ny, f, no}
  always_comb begin
    xa = ctrl_i[5] ? '0 : x_i;
    xb = ctrl_i[4] ? ~xa : xa;
    ya = ctrl_i[3] ? '0 : y_i;
    yb = ctrl_i[2] ? ~ya : ya;
    f = ctrl_i[1] ? xb + yb : xb & yb;
    out_o = ctrl_i[0] ? ~f : f;
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH     = 16,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_x_i,
  input  logic [WIDTH-1:0] req0_y_i,
  input  logic [5:0]       req0_ctrl_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_x_i,
  input  logic [WIDTH-1:0] req1_y_i,
  input  logic [5:0]       req1_ctrl_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_out_o,
  output logic             rsp_ng_o,
  output logic             rsp_zr_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, id_q, id_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, rsp_out_q, rsp_out_d, alu_out;
  logic [5:0] ctrl_q, ctrl_d;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_ng_q, rsp_ng_d, rsp_zr_q, rsp_zr_d;
  logic [1:0] vld;
  logic gnt, take;

  hack_alu #(.W(WIDTH)) u_alu (.x_i(x_q), .y_i(y_q), .ctrl_i(ctrl_q), .out_o(alu_out));

  // Grant the priority holder if it asks, otherwise the other side; only offered while idle
  always_comb begin
    vld = {req1_valid_i, req0_valid_i};
    gnt = vld[prio_q] ? prio_q : ~prio_q;
    take = (state_q == IDLE) && vld[gnt];
    req0_ready_o = take && !gnt;
    req1_ready_o = take && gnt;
  end

  // Next-state and datapath updates for accept, evaluate and response hand-off
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    id_d = id_q;
    x_d = x_q;
    y_d = y_q;
    ctrl_d = ctrl_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_out_d = rsp_out_q;
    rsp_ng_d = rsp_ng_q;
    rsp_zr_d = rsp_zr_q;
    case (state_q)
      IDLE: if (take) begin
        x_d = gnt ? req1_x_i : req0_x_i;
        y_d = gnt ? req1_y_i : req0_y_i;
        ctrl_d = gnt ? req1_ctrl_i : req0_ctrl_i;
        id_d = gnt;
        state_d = EXEC;
      end
      EXEC: begin
        rsp_out_d = alu_out;
        rsp_ng_d = alu_out[WIDTH-1];
        rsp_zr_d = alu_out == '0;
        rsp_id_d = id_q;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        prio_d = ~rsp_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any operation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Operand, priority and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= INIT_PRIO;
      id_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      ctrl_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_out_q <= '0;
      rsp_ng_q <= 1'b0;
      rsp_zr_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      id_q <= id_d;
      x_q <= x_d;
      y_q <= y_d;
      ctrl_q <= ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_ng_q <= rsp_ng_d;
      rsp_zr_q <= rsp_zr_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_out_o = rsp_out_q;
  assign rsp_ng_o = rsp_ng_q;
  assign rsp_zr_o = rsp_zr_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, back-pressure and reset abort
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 0, v1 = 0, rdy0, rdy1, rsp_ready = 0;
  logic [15:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0, rsp_out;
  logic [5:0] c0 = 0, c1 = 0;
  logic rsp_valid, rsp_id, ng, zr, busy;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16), .INIT_PRIO(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_x_i(x0), .req0_y_i(y0), .req0_ctrl_i(c0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_x_i(x1), .req1_y_i(y1), .req1_ctrl_i(c1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_out_o(rsp_out),
    .rsp_ng_o(ng), .rsp_zr_o(zr), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_rsp(input string tag, input logic [15:0] out, input logic id);
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_out"}, rsp_out, out);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_ng"}, ng, out[15]);
    chk({tag, "_zr"}, zr, out == 16'h0);
  endtask

  initial begin
    int n, last;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rdy1", rdy1, 0);
    chk("rst_out", rsp_out, 0);
    chk("rst_id", rsp_id, 0);
    // 1: single add from requester 0
    v0 = 1; x0 = 16'h1234; y0 = 16'h4321; c0 = 6'b000010;
    #1 chk("t1_rdy0", rdy0, 1);
    chk("t1_rdy1", rdy1, 0);
    @(negedge clk); v0 = 0;
    #1 chk("t1_busy", busy, 1);
    chk("t1_rdy0_exec", rdy0, 0);
    chk("t1_vld_exec", rsp_valid, 0);
    @(negedge clk); expect_rsp("t1", 16'h5555, 0); rsp_ready = 1;
    @(negedge clk); chk("t1_done", rsp_valid, 0); chk("t1_idle", busy, 0); rsp_ready = 0;
    // 2: x-y from requester 1
    v1 = 1; x1 = 16'h0001; y1 = 16'h0002; c1 = 6'b010011;
    #1 chk("t2_rdy1", rdy1, 1);
    chk("t2_rdy0", rdy0, 0);
    @(negedge clk); v1 = 0;
    @(negedge clk); expect_rsp("t2", 16'hFFFF, 1); rsp_ready = 1;
    @(negedge clk); chk("t2_done", rsp_valid, 0);
    // 3: simultaneous requests, priority back on 0
    v0 = 1; x0 = 16'hAAAA; y0 = 16'h5555; c0 = 6'b101010;
    v1 = 1; x1 = 16'hAAAA; y1 = 16'h5555; c1 = 6'b111010;
    #1 chk("t3_rdy0", rdy0, 1);
    chk("t3_rdy1", rdy1, 0);
    @(negedge clk); v0 = 0;
    #1 chk("t3_rdy1_exec", rdy1, 0);
    @(negedge clk); expect_rsp("t3a", 16'h0000, 0);
    @(negedge clk); chk("t3_gap", rsp_valid, 0); chk("t3_rdy1_next", rdy1, 1);
    @(negedge clk); v1 = 0;
    @(negedge clk); expect_rsp("t3b", 16'hFFFF, 1);
    @(negedge clk); chk("t3_done", rsp_valid, 0); rsp_ready = 0;
    // 4: response back-pressure while requester 1 waits
    v0 = 1; x0 = 16'h0003; y0 = 16'h0004; c0 = 6'b000010;
    @(negedge clk); v0 = 0; v1 = 1; x1 = 16'h0010; y1 = 16'h0001; c1 = 6'b010011;
    @(negedge clk); expect_rsp("t4", 16'h0007, 0);
    repeat (5) begin
      @(negedge clk);
      expect_rsp("t4_hold", 16'h0007, 0);
      chk("t4_busy", busy, 1);
      chk("t4_rdy0", rdy0, 0);
      chk("t4_rdy1", rdy1, 0);
    end
    rsp_ready = 1;
    @(negedge clk); chk("t4_drop", rsp_valid, 0); chk("t4_rdy1_next", rdy1, 1);
    @(negedge clk); v1 = 0;
    @(negedge clk); expect_rsp("t4b", 16'h000F, 1);
    @(negedge clk); chk("t4_done", rsp_valid, 0);
    // 5: reset during execute of a requester-0 op, with priority moved to 1 first
    v0 = 1; x0 = 16'h0005; y0 = 16'h0005; c0 = 6'b000010;
    @(negedge clk); v0 = 0;
    @(negedge clk); expect_rsp("t5a", 16'h000A, 0);
    @(negedge clk); chk("t5a_done", rsp_valid, 0);
    v0 = 1; x0 = 16'h0007;
    @(negedge clk); v0 = 0;
    chk("t5_exec", busy, 1);
    #2 rst = 1;
    #1 chk("t5_rst_busy", busy, 0);
    chk("t5_rst_vld", rsp_valid, 0);
    #2 rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 0);
      chk("t5_idle", busy, 0);
    end
    v0 = 1; x0 = 16'h0100; y0 = 16'h0023; c0 = 6'b000010; v1 = 1;
    #1 chk("t5_prio_rdy0", rdy0, 1);
    chk("t5_prio_rdy1", rdy1, 0);
    @(negedge clk); v0 = 0; v1 = 0;
    @(negedge clk); expect_rsp("t5b", 16'h0123, 0);
    @(negedge clk); chk("t5_done", rsp_valid, 0);
    // 6: continuous load from both, consumer always ready
    rst = 1;
    @(negedge clk); rst = 0;
    v0 = 1; x0 = 16'h00FF; y0 = 16'h0F0F; c0 = 6'b000000;
    v1 = 1; x1 = 16'h00FF; y1 = 16'h0F0F; c1 = 6'b000000;
    rsp_ready = 1;
    n = 0; last = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("t6_out", rsp_out, 16'h000F);
        chk("t6_id", rsp_id, n % 2);
        if (n > 0) chk("t6_gap", c - last, 3);
        last = c;
        n++;
      end
    end
    chk("t6_count", n, 4);
    v0 = 0; v1 = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
